// File: rtl/shared_pkg.sv
// ============================================================================
//  Module      : shared_pkg
//  Description : Shared AXI burst, response and write-FSM types.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shared_pkg;

    typedef enum logic [1:0] {
        FIXED    = 2'b00,
        INCR     = 2'b01,
        WRAP     = 2'b10,
        RESERVED = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } wr_state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        logic ok;
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
// ============================================================================
//  Module      : axi_burst_addr_gen
//  Description : Combinational next-beat address for FIXED/INCR (and WRAP
//                when AXI_WR_WRAP_EN is defined) AXI bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_addr_gen
    import shared_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  burst_e                burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_incr;

    assign w_bytes = ADDR_WIDTH'(1) << size;
    assign w_incr  = (addr & ~(w_bytes - ADDR_WIDTH'(1))) + w_bytes;

`ifdef AXI_WR_WRAP_EN
    logic [ADDR_WIDTH-1:0] w_wrap_size;
    logic [ADDR_WIDTH-1:0] w_lower;
    logic [ADDR_WIDTH-1:0] w_wrap_next;

    assign w_wrap_size = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    assign w_lower     = addr & ~(w_wrap_size - ADDR_WIDTH'(1));
    assign w_wrap_next = (w_incr == w_lower + w_wrap_size) ? w_lower : w_incr;
`else
    logic w_unused_len;
    assign w_unused_len = ^len;
`endif

    always_comb begin
        next_addr = addr;
        case (burst)
            INCR:    next_addr = w_incr;
`ifdef AXI_WR_WRAP_EN
            WRAP:    next_addr = w_wrap_next;
`endif
            default: next_addr = addr;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/axi_wr_slave_mem.sv
// ============================================================================
//  Module      : axi_wr_slave_mem
//  Description : AXI4 write-path slave committing bursts into a word memory,
//                with a combinational debug read port. WRAP bursts are
//                enabled by defining AXI_WR_WRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_wr_slave_mem
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [ID_WIDTH-1:0]          awid,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [7:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [ID_WIDTH-1:0]          bid,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_rdata
);

    localparam int c_strb_w = DATA_WIDTH / 8;
    localparam int c_log2b  = $clog2(c_strb_w);
    localparam int c_idx_w  = $clog2(MEM_DEPTH);

    wr_state_e             r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    burst_e                r_burst;
    logic [7:0]            r_beat_cnt;
    logic                  r_err;
    logic                  r_nowrite;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic                  w_in_range;
    logic                  w_wfire;
    logic                  w_last_beat;
    logic                  w_err_next;
    logic                  w_aw_bad;
    logic                  w_we;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (r_addr),
        .size      (r_size),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (w_next_addr)
    );

    // Bursts rejected at AW time still drain len+1 beats but write nothing.
    always_comb begin
        w_aw_bad = 1'b0;
        if (awsize > 3'(c_log2b)) begin
            w_aw_bad = 1'b1;
        end
        case (awburst)
            2'b11: w_aw_bad = 1'b1;
            2'b10: begin
`ifdef AXI_WR_WRAP_EN
                if (!wrap_len_ok(awlen) ||
                    ((awaddr & ((ADDR_WIDTH'(1) << awsize) - ADDR_WIDTH'(1))) != '0)) begin
                    w_aw_bad = 1'b1;
                end
`else
                w_aw_bad = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign w_word_idx  = r_addr >> c_log2b;
    assign w_in_range  = w_word_idx < ADDR_WIDTH'(MEM_DEPTH);
    assign w_wfire     = (r_state == DATA) && wvalid && wready;
    assign w_last_beat = (r_beat_cnt == r_len);
    assign w_err_next  = r_err || !w_in_range || (wlast != w_last_beat);
    assign w_we        = w_wfire && !r_nowrite && w_in_range;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= IDLE;
            awready    <= 1'b1;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bid        <= '0;
            bresp      <= OKAY;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= FIXED;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_nowrite  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (awvalid && awready) begin
                        r_id       <= awid;
                        r_addr     <= awaddr;
                        r_len      <= awlen;
                        r_size     <= awsize;
                        r_burst    <= burst_e'(awburst);
                        r_beat_cnt <= '0;
                        r_err      <= w_aw_bad;
                        r_nowrite  <= w_aw_bad;
                        awready    <= 1'b0;
                        wready     <= 1'b1;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_wfire) begin
                        r_addr     <= w_next_addr;
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        r_err      <= w_err_next;
                        if (w_last_beat) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= r_id;
                            bresp   <= w_err_next ? SLVERR : OKAY;
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int b = 0; b < c_strb_w; b++) begin
                if (wstrb[b]) begin
                    mem[w_word_idx[c_idx_w-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign dbg_rdata = mem[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_slave_mem.sv
// ============================================================================
//  Module      : tb_axi_wr_slave_mem
//  Description : Self-checking bench for axi_wr_slave_mem against a
//                behavioural memory/response model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_wr_slave_mem;

    localparam int MD = 1024;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awid    = '0;
    logic [15:0] awaddr  = '0;
    logic [7:0]  awlen   = '0;
    logic [2:0]  awsize  = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata   = '0;
    logic [3:0]  wstrb   = '0;
    logic        wlast   = 1'b0;
    logic        wvalid  = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready  = 1'b0;
    logic [9:0]  dbg_addr = '0;
    logic [31:0] dbg_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [MD];
    logic [31:0] bd [256];
    logic [3:0]  bs [256];

    always #5 aclk = ~aclk;

    axi_wr_slave_mem #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .ID_WIDTH   (4),
        .MEM_DEPTH  (MD)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Byte address of beat i, straight from the burst definitions.
    function automatic int beat_addr(input int addr, input int len, input int size,
                                     input int burst, input int i);
        int bytes;
        int ws;
        int lo;
        bytes = 1 << size;
        if (burst == 0 || i == 0) return addr;
        if (burst == 1) return ((addr & ~(bytes - 1)) + i * bytes) & 32'hFFFF;
        ws = bytes * (len + 1);
        lo = addr & ~(ws - 1);
        return lo + ((addr - lo + i * bytes) % ws);
    endfunction

    function automatic logic [1:0] model_burst(input int addr, input int len, input int size,
                                               input int burst, input int flip);
        bit err;
        bit nowr;
        int w;
        err  = 1'b0;
        nowr = 1'b0;
        if (size > 2) begin err = 1'b1; nowr = 1'b1; end
        if (burst == 3) begin err = 1'b1; nowr = 1'b1; end
        if (burst == 2) begin
`ifdef AXI_WR_WRAP_EN
            if (!(len == 1 || len == 3 || len == 7 || len == 15) || (addr % (1 << size)) != 0) begin
                err = 1'b1; nowr = 1'b1;
            end
`else
            err = 1'b1; nowr = 1'b1;
`endif
        end
        for (int i = 0; i <= len; i++) begin
            if (i == flip) err = 1'b1;
            if (!nowr) begin
                w = beat_addr(addr, len, size, burst, i) >> 2;
                if (w >= MD) err = 1'b1;
                else begin
                    for (int b = 0; b < 4; b++)
                        if (bs[i][b]) ref_mem[w][b*8 +: 8] = bd[i][b*8 +: 8];
                end
            end
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    task automatic rd(input int idx, output logic [31:0] v);
        dbg_addr = 10'(idx);
        #1;
        v = dbg_rdata;
    endtask

    task automatic sweep(input string tag);
        logic [31:0] v;
        for (int i = 0; i < MD; i++) begin
            rd(i, v);
            chk($sformatf("%s[%0d]", tag, i), v, ref_mem[i]);
        end
    endtask

    task automatic run_burst(input logic [3:0] id, input int addr, input int len, input int size,
                             input int burst, input int flip, input int bw, input bit gaps);
        logic [1:0] e_resp;
        int t;
        e_resp = model_burst(addr, len, size, burst, flip);
        @(negedge aclk);
        awid = id; awaddr = 16'(addr); awlen = 8'(len); awsize = 3'(size);
        awburst = 2'(burst); awvalid = 1'b1;
        t = 0;
        while (!awready && t < 20) begin @(negedge aclk); t++; end
        chk("aw_ready", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        chk("w_ready_zero_wait", wready, 1);
        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(negedge aclk);
            end
            wvalid = 1'b1; wdata = bd[i]; wstrb = bs[i];
            wlast = (i == len) ^ (i == flip);
            t = 0;
            while (!wready && t < 20) begin @(negedge aclk); t++; end
            chk("w_ready", wready, 1);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("b_valid_latency", bvalid, 1);
        chk("b_id", bid, id);
        chk("b_resp", bresp, e_resp);
        for (int k = 0; k < bw; k++) begin
            @(negedge aclk);
            chk("b_hold_valid", bvalid, 1);
            chk("b_hold_id", bid, id);
            chk("b_hold_resp", bresp, e_resp);
            chk("aw_blocked", awready, 0);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("b_done", bvalid, 0);
        chk("aw_ready_after_b", awready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int addr, len, size, burst, flip;

        repeat (2) @(negedge aclk);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_bresp", bresp, 0);
        aresetn = 1'b1;

        // Fill memory so every word has a known value.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 256; i++) begin bd[i] = $urandom; bs[i] = 4'hF; end
            run_burst(4'(p), p * 1024, 255, 2, 1, -1, 0, 1'b0);
        end
        sweep("preload");

        for (int i = 0; i < 4; i++) begin bd[i] = 32'hA0 + i; bs[i] = 4'hF; end
        run_burst(4'd5, 'h10, 3, 2, 1, -1, 5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd(4 + i, v);
            chk($sformatf("incr_word%0d", 4 + i), v, 32'hA0 + i);
        end

        bd[0] = 32'h11223344; bs[0] = 4'hF;
        bd[1] = 32'hFFFFFFFF; bs[1] = 4'h1;
        run_burst(4'd2, 'h20, 1, 2, 0, -1, 0, 1'b0);
        rd(8, v);
        chk("fixed_strobe_word8", v, 32'h112233FF);

        for (int i = 0; i < 3; i++) begin bd[i] = $urandom; bs[i] = 4'hF; end
        run_burst(4'd7, (MD - 1) * 4, 1, 2, 1, -1, 1, 1'b0);
        rd(MD - 1, v);
        chk("oob_last_word", v, bd[0]);
        run_burst(4'd8, 'h200, 2, 2, 1, 0, 0, 1'b0);
        run_burst(4'd9, 'h300, 1, 3, 1, -1, 0, 1'b0);
        sweep("errors");

        // Abort a burst with reset after beat 1.
        for (int i = 0; i < 2; i++) begin bd[i] = $urandom; bs[i] = 4'hF; end
        @(negedge aclk);
        awid = 4'd3; awaddr = 16'h0100; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = bd[i]; wstrb = bs[i]; wlast = 1'b0;
            @(negedge aclk);
        end
        wvalid = 1'b0;
        ref_mem[64] = bd[0];
        ref_mem[65] = bd[1];
        #2 aresetn = 1'b0;
        #1;
        chk("rst_async_wready", wready, 0);
        chk("rst_async_bvalid", bvalid, 0);
        chk("rst_async_awready", awready, 1);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_release_awready", awready, 1);
        rd(64, v);
        chk("rst_beat0_kept", v, bd[0]);
        for (int i = 0; i < 4; i++) begin bd[i] = $urandom; bs[i] = 4'hF; end
        run_burst(4'd4, 'h180, 3, 2, 1, -1, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin bd[i] = 32'hC0 + i; bs[i] = 4'hF; end
        run_burst(4'd6, 'h38, 3, 2, 2, -1, 0, 1'b0);
`ifdef AXI_WR_WRAP_EN
        rd(14, v); chk("wrap_word14", v, 32'hC0);
        rd(15, v); chk("wrap_word15", v, 32'hC1);
        rd(12, v); chk("wrap_word12", v, 32'hC2);
        rd(13, v); chk("wrap_word13", v, 32'hC3);
`endif
        sweep("directed");

        for (int r = 0; r < 30; r++) begin
            burst = $urandom_range(0, 3);
            size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            len   = $urandom_range(0, 15);
            if (burst == 2 && $urandom_range(0, 7) != 0) begin
                case ($urandom_range(0, 3))
                    0:       len = 1;
                    1:       len = 3;
                    2:       len = 7;
                    default: len = 15;
                endcase
            end
            addr = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 4095);
            if (burst == 2 && $urandom_range(0, 4) != 0) addr = addr & ~((1 << size) - 1);
            flip = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : -1;
            for (int i = 0; i <= len; i++) begin bd[i] = $urandom; bs[i] = 4'($urandom); end
            run_burst(4'($urandom), addr, len, size, burst, flip, $urandom_range(0, 3), 1'b1);
            sweep("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_wr_slave_mem.md
Name: axi_wr_slave_mem

Overview:
- AXI4 write-path slave that consumes the AW, W and B channels of the team's AXI interface and commits write bursts into an internal word-addressed memory.
- Sits directly downstream of the AXI interface, as the slave-side endpoint behind the write modport.
- Supports FIXED and INCR bursts and narrow transfers, and returns OKAY or SLVERR per burst.
- A combinational debug read port lets the bench inspect memory contents.

Parameters:
- DATA_WIDTH, 32: W data width in bits. Legal values are 32 or 64.
- ADDR_WIDTH, 16: AW address width in bits.
- ID_WIDTH, 4: AWID/BID width in bits.
- MEM_DEPTH, 1024: number of DATA_WIDTH words in the memory.

Ports:
- aclk  in  1: clock.
- aresetn  in  1: asynchronous active-low reset.
- awid  in  ID_WIDTH: write transaction ID.
- awaddr  in  ADDR_WIDTH: byte start address.
- awlen  in  8: beats minus 1.
- awsize  in  3: log2 of bytes per beat.
- awburst  in  2: burst type (FIXED/INCR/WRAP).
- awvalid  in  1 / awready  out  1: AW handshake.
- wdata  in  DATA_WIDTH: write data.
- wstrb  in  DATA_WIDTH/8: byte enables.
- wlast  in  1: final beat marker.
- wvalid  in  1 / wready  out  1: W handshake.
- bid  out  ID_WIDTH: response ID.
- bresp  out  2: response code.
- bvalid  out  1 / bready  in  1: B handshake.
- dbg_addr  in  $clog2(MEM_DEPTH): word index to inspect.
- dbg_rdata  out  DATA_WIDTH: combinational memory read.

Behaviour:
- Reset values: awready=1, wready=0, bvalid=0, bid=0, bresp=OKAY, FSM in IDLE.
- Reset does not clear memory contents.
- Asserting aresetn low mid-burst aborts the burst immediately; no response is issued for it.
- FSM has three states: IDLE, DATA, RESP.
- IDLE:
  - awready=1.
  - On awvalid&&awready, latch id, addr, len, size and burst; clear beat_cnt and err; go to DATA.
  - wready rises the next cycle. AW is accepted with zero wait.
- DATA:
  - awready=0, wready=1.
  - On each W handshake, the beat is written to word addr>>log2(DATA_WIDTH/8).
  - Only bytes with wstrb=1 are written.
  - The address then advances per burst type.
  - On the handshake where beat_cnt==len, go to RESP.
- RESP:
  - bvalid=1, bid=latched id, bresp = err ? SLVERR(2'b10) : OKAY(2'b00).
  - Outputs hold stable until bready.
  - On bvalid&&bready, return to IDLE; awready=1 that same next cycle.
- Latency: bvalid asserts the cycle after the final W handshake.
- Address advance:
  - FIXED: address unchanged.
  - INCR: next = aligned(addr, size) + 2^size.
  - The first beat uses the unaligned address; its word index is still addr>>log2(bytes).
- Error rules (each sets err; the burst still consumes exactly len+1 beats):
  - awsize > log2(DATA_WIDTH/8): no beats are written.
  - Beat word index >= MEM_DEPTH: that beat is not written; other beats are written.
  - wlast=1 on a beat other than the last, or wlast=0 on the last beat.
  - awburst=2'b11 (reserved): no beats are written.
- Simultaneous events: RESP→IDLE and a new awvalid are accepted no earlier than the IDLE cycle. No overlap of bursts.
- Address arithmetic is ADDR_WIDTH wide; INCR wrap-around past 2^ADDR_WIDTH rolls to 0.
- dbg_rdata = mem[dbg_addr], combinational.

Optional Feature:
- AXI_WR_WRAP_EN defined:
  - WRAP bursts are supported.
  - len must be 1, 3, 7 or 15, and awaddr must be aligned to 2^size; otherwise SLVERR and no writes.
  - wrap_size = 2^size*(len+1); lower = addr & ~(wrap_size-1).
  - When next address == lower+wrap_size, it becomes lower.
- Undefined: awburst=WRAP behaves like the reserved type (SLVERR, no writes, len+1 beats consumed).

Decomposition:
- shared_pkg holds:
  - burst_e: FIXED=2'b00, INCR=2'b01, WRAP=2'b10, RESERVED=2'b11.
  - resp_e: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - wr_state_e: IDLE, DATA, RESP.
- One sub-module, axi_burst_addr_gen: combinational next-address calculation from addr, size, len and burst. It contains the WRAP logic under the macro.

Test Plan:
- INCR write: awaddr=0x10, len=3, size=2, wdata 0xA0..0xA3, wstrb=0xF, wlast on beat 3 -> words 4..7 = 0xA0..0xA3; bresp=OKAY; bid echoes awid=5; bvalid 1 cycle after the last W.
- FIXED with strobes: awaddr=0x20, len=1, size=2. Beat0 0x11223344 wstrb=0xF, beat1 0xFFFFFFFF wstrb=0x1 -> word 8 = 0x112233FF; OKAY.
- Backpressure: bready low for 5 cycles -> bvalid, bid and bresp stable; awready stays 0 until the cycle after bready.
- Errors:
  - Start word MEM_DEPTH-1, len=1 -> last word written, second beat dropped, SLVERR.
  - Early wlast on beat 0 of len=2 -> 3 beats consumed, SLVERR.
  - awsize=3 with DATA_WIDTH=32 -> no writes, SLVERR.
- Reset mid-burst: aresetn low after beat 1 of len=3 -> wready=0 and bvalid=0 asynchronously, awready=1 after release, beat 0 data retained, new burst completes with OKAY.
- WRAP with AXI_WR_WRAP_EN: awaddr=0x38, len=3, size=2 -> words 14, 15, 12, 13 written; OKAY. Without the macro -> no writes, SLVERR.
